// File: rtl/n_mem_arbiter.sv
// Round-robin arbiter sharing the single read port of the modulus ROM (n_mem)
// between two burst requesters. Drives one address per cycle and carries a
// {valid, owner, last} tag alongside each address to match the 2-cycle ROM latency.
module n_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] base0,
    input  logic [ADDR_WIDTH:0]   len0,
    output logic                  ack0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  done0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] base1,
    input  logic [ADDR_WIDTH:0]   len1,
    output logic                  ack1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  done1,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  drain_q, drain_d;
    // Latency pipeline: stage 1 lines up with the ROM address register,
    // stage 2 with the ROM output register.
    logic                  p1_valid_q, p1_owner_q, p1_last_q;
    logic                  p2_valid_q, p2_owner_q, p2_last_q;

    logic elig0, elig1, grant;

    assign elig0 = req0 && (len0 != '0);
    assign elig1 = req1 && (len1 != '0);

    // Next-state: arbitration in idle, address stepping in burst, latency flush in drain.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        drain_d      = drain_q;
        grant        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (elig0 || elig1) begin
                    // With both eligible, the one that did not win last time goes first.
                    grant        = (elig0 && elig1) ? ~last_grant_q : elig1;
                    addr_d       = grant ? base1 : base0;
                    len_d        = grant ? len1 : len0;
                    owner_d      = grant;
                    last_grant_d = grant;
                    cnt_d        = (ADDR_WIDTH + 1)'(1);
                    ack0_d       = ~grant;
                    ack1_d       = grant;
                    state_d      = StBurst;
                end
            end
            StBurst: begin
                // cnt_q counts addresses already presented, including the current one.
                if (cnt_q == len_q) begin
                    state_d = StDrain;
                    drain_d = 1'b0;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    cnt_d  = cnt_q + (ADDR_WIDTH + 1)'(1);
                end
            end
            StDrain: begin
                if (drain_q) begin
                    state_d = StIdle;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, address and tag pipeline registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            drain_q      <= 1'b0;
            p1_valid_q   <= 1'b0;
            p1_owner_q   <= 1'b0;
            p1_last_q    <= 1'b0;
            p2_valid_q   <= 1'b0;
            p2_owner_q   <= 1'b0;
            p2_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            drain_q      <= drain_d;
            p1_valid_q   <= (state_q == StBurst);
            p1_owner_q   <= owner_q;
            p1_last_q    <= (state_q == StBurst) && (cnt_q == len_q);
            p2_valid_q   <= p1_valid_q;
            p2_owner_q   <= p1_owner_q;
            p2_last_q    <= p1_last_q;
        end
    end

    // Outputs: registered address/acks, returned-data strobes from the pipeline tail.
    always_comb begin
        mem_address = addr_q;
        ack0        = ack0_q;
        ack1        = ack1_q;
        busy        = (state_q != StIdle);
        rvalid0     = p2_valid_q && !p2_owner_q;
        rvalid1     = p2_valid_q && p2_owner_q;
        done0       = p2_valid_q && p2_last_q && !p2_owner_q;
        done1       = p2_valid_q && p2_last_q && p2_owner_q;
        rdata0      = mem_q;
        rdata1      = mem_q;
    end

endmodule

// File: doc/n_mem_arbiter.md
Name: n_mem_arbiter

Overview:
- Shares the single read port of the modulus ROM (n_mem: M4K single-port, read-only, registered address and registered output) between two requesters.
- Example requesters: the Montgomery multiplier and the final-subtraction unit.
- Each requester asks for a burst of consecutive words. The arbiter grants round-robin, drives the ROM address one word per cycle and tracks the 2-cycle ROM latency.
- It returns data with per-requester valid and done strobes.

Parameters:
- ADDR_WIDTH, 7, ROM address width (matches `ADDR_WIDTH).
- DATA_WIDTH, 32, ROM word width (matches `DATA_WIDTH).

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 burst request; held until ack0
- base0  in  ADDR_WIDTH  requester 0 first word address
- len0  in  ADDR_WIDTH+1  requester 0 word count, 1..2^ADDR_WIDTH
- ack0  out  1  one-cycle pulse: burst 0 accepted
- rvalid0  out  1  rdata0 holds a valid word
- rdata0  out  DATA_WIDTH  word returned to requester 0
- done0  out  1  pulse coincident with the last rvalid0 of a burst
- req1, base1, len1, ack1, rvalid1, rdata1, done1: same as above, for requester 1
- mem_address  out  ADDR_WIDTH  to n_mem address
- mem_q  in  DATA_WIDTH  from n_mem q
- busy  out  1  burst in progress, including drain

Behaviour:
- Reset: state=IDLE.
  - ack0/1, rvalid0/1, done0/1, busy = 0; mem_address = 0.
  - Word counter = 0; latency pipeline valid bits cleared.
  - last_grant = 1, so requester 0 wins the first contention.
- rdata0 and rdata1 are mem_q passed through combinationally; they are meaningful only while the matching rvalid is high. n_mem wren is tied 0; this block never writes.
- Eligibility: reqN=1 and lenN != 0. A request with len=0 is ignored and never acked.
- States:
  - IDLE: sample eligible requests.
    - One eligible: grant it.
    - Both eligible: grant the one != last_grant.
    - On grant at cycle T: latch base, len and owner; update last_grant; go to BURST.
    - ackN is high for cycle T+1 only.
  - BURST: mem_address = base+i (mod 2^ADDR_WIDTH) in cycle T+1+i, for i = 0..len-1.
    - mem_address is a registered output.
    - After address len-1 is issued, go to DRAIN.
    - req inputs are not sampled here.
  - DRAIN: 2 cycles, to flush the ROM latency; then IDLE.
    - mem_address holds its last value.
- Latency: the word for an address issued in cycle C appears on mem_q in C+2.
  - A 2-stage shift register carries {valid, owner, last} alongside each address.
  - rvalidN=1 in cycles T+3 .. T+len+2; doneN=1 in T+len+2.
- busy = 1 from T+1 through T+len+2.
- IDLE is re-entered at T+len+3, so the minimum gap from one ack to the next is len+3 cycles.
- Requester protocol:
  - Deassert reqN the cycle after ackN; if reqN is still high in IDLE, a new burst starts.
  - base/len may change after ack; the latched copies are used.
  - Dropping req mid-burst does not abort the burst.
- Address wrap: base+i wraps modulo 2^ADDR_WIDTH, with no error. Example: base=126, len=4 → 126, 127, 0, 1.
- len = 2^ADDR_WIDTH (128) is legal; the word counter is ADDR_WIDTH+1 bits wide.
- Simultaneous requests in the same cycle: round-robin as above. The loser keeps req high and is granted at the next IDLE.
- Reset mid-burst or mid-drain:
  - Return immediately to reset values.
  - In-flight words are discarded; no rvalid or done is produced.
  - No ack is issued until a new request is seen in IDLE.
- Only one owner at a time. rvalid0 and rvalid1 are never high in the same cycle; done0 and done1 likewise.

Test Plan:
- Single burst: req0=1, base0=5, len0=3 sampled at T.
  - ack0 at T+1.
  - mem_address 5, 6, 7 at T+1..T+3.
  - rvalid0 at T+3..T+5 with ROM words 5, 6, 7.
  - done0 at T+5; busy low at T+6.
- Contention after reset: req0 and req1 both rise at T (len=2 each).
  - Requester 0 is granted first: ack0 at T+1, done0 at T+4.
  - ack1 at T+6; rvalid1 is never asserted during burst 0.
  - A second simultaneous contention is then granted to requester 0 (round-robin alternates).
- Wrap: base1=126, len1=4 → mem_address 126, 127, 0, 1; rdata1 carries ROM words 126, 127, 0, 1 in order.
- Full ROM: base0=0, len0=128 → 128 consecutive rvalid0 cycles, addresses 0..127; done0 only on the 128th.
- Reset mid-burst: assert reset during the 3rd address of a len=8 burst.
  - Next cycle: all outputs are 0 and state is IDLE.
  - No further rvalid or done appears.
  - A fresh req1 afterwards is acked normally.
- len=0: req0=1, len0=0, held for 10 cycles → no ack0, busy stays 0. A concurrent req1 with len1=2 is served.
